// File: rtl/rob_pkg.sv
// Shared reorder-buffer types. The depth is 2**`ROB_SIZE_WIDTH, taken from the global define.
// The define falls back to 3 (an 8-entry buffer) when nothing upstream provides it.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 3
`endif

package rob_pkg;
    localparam int ROB_TAG_W = `ROB_SIZE_WIDTH;
    localparam int ROB_SIZE  = 1 << ROB_TAG_W;

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;
    typedef logic [ROB_TAG_W:0]   rob_cnt_t;

    // Control flags only; the register payload lives in arrays sized by module parameters.
    typedef struct packed {
        logic valid;
        logic done;
        logic is_branch;
        logic has_dest;
    } rob_entry_t;

    function automatic rob_tag_t rob_tag_inc(input rob_tag_t t);
        return t + rob_tag_t'(1);
    endfunction
endpackage

// File: rtl/rob_commit_stats.sv
// Commit statistics counters for the reorder buffer. All counters wrap modulo 2**32.
// This module is instantiated only when ROB_COMMIT_STATS_EN is defined.
module rob_commit_stats (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_i,
    input  logic        branch_i,
    input  logic        full_i,
    output logic [31:0] commits_o,
    output logic [31:0] branch_commits_o,
    output logic [31:0] full_cycles_o
);
    logic [31:0] commits_q, branch_q, full_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            commits_q <= '0;
            branch_q  <= '0;
            full_q    <= '0;
        end else begin
            if (commit_i)             commits_q <= commits_q + 32'd1;
            if (commit_i && branch_i) branch_q  <= branch_q + 32'd1;
            if (full_i)               full_q    <= full_q + 32'd1;
        end
    end

    assign commits_o        = commits_q;
    assign branch_commits_o = branch_q;
    assign full_cycles_o    = full_q;
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: it allocates tags at dispatch, marks entries done at writeback,
// and retires the head entry once per cycle. Define ROB_COMMIT_STATS_EN to add the stat_* counters.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int PREG_WIDTH = 6,
    parameter int AREG_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alloc_valid,
    input  logic                  alloc_is_branch,
    input  logic                  alloc_has_dest,
    input  logic [AREG_WIDTH-1:0] alloc_dest_arch,
    input  logic [PREG_WIDTH-1:0] alloc_dest_preg,
    input  logic [PREG_WIDTH-1:0] alloc_old_preg,
    output rob_tag_t              alloc_tag,
    output logic                  rob_full,
    output logic                  rob_empty,
    input  logic                  wb_valid,
    input  rob_tag_t              wb_tag,
    output logic                  commit_valid,
    output logic                  commited_branch_op,
    output rob_tag_t              commited_branch_tag,
    output logic                  commit_has_dest,
    output logic [AREG_WIDTH-1:0] commit_dest_arch,
    output logic [PREG_WIDTH-1:0] commit_dest_preg,
    output logic [PREG_WIDTH-1:0] commit_old_preg
`ifdef ROB_COMMIT_STATS_EN
    ,
    output logic [31:0]           stat_commits,
    output logic [31:0]           stat_branch_commits,
    output logic [31:0]           stat_full_cycles
`endif
);
    localparam rob_cnt_t FULL_CNT = rob_cnt_t'(ROB_SIZE);

    rob_entry_t            ent_q   [ROB_SIZE];
    logic [AREG_WIDTH-1:0] arch_q  [ROB_SIZE];
    logic [PREG_WIDTH-1:0] dpreg_q [ROB_SIZE];
    logic [PREG_WIDTH-1:0] opreg_q [ROB_SIZE];

    rob_tag_t head_q, head_d, tail_q, tail_d;
    rob_cnt_t count_q, count_d;
    logic     alloc_fire, commit_fire;

    // Fullness comes from registered count only, so a commit never frees a slot in its own cycle.
    assign rob_full    = (count_q == FULL_CNT);
    assign rob_empty   = (count_q == '0);
    assign alloc_tag   = tail_q;
    assign alloc_fire  = alloc_valid && !rob_full;
    assign commit_fire = ent_q[head_q].valid && ent_q[head_q].done;

    assign commit_valid        = commit_fire;
    assign commited_branch_op  = commit_fire && ent_q[head_q].is_branch;
    assign commited_branch_tag = commit_fire ? head_q : '0;
    assign commit_has_dest     = commit_fire && ent_q[head_q].has_dest;
    assign commit_dest_arch    = commit_fire ? arch_q[head_q]  : '0;
    assign commit_dest_preg    = commit_fire ? dpreg_q[head_q] : '0;
    assign commit_old_preg     = commit_fire ? opreg_q[head_q] : '0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (alloc_fire)  tail_d = rob_tag_inc(tail_q);
        if (commit_fire) head_d = rob_tag_inc(head_q);
        case ({alloc_fire, commit_fire})
            2'b10:   count_d = count_q + rob_cnt_t'(1);
            2'b01:   count_d = count_q - rob_cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ROB_SIZE; i++) ent_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (wb_valid && ent_q[wb_tag].valid) ent_q[wb_tag].done <= 1'b1;
            if (commit_fire) ent_q[head_q].valid <= 1'b0;
            if (alloc_fire) begin
                ent_q[tail_q] <= '{valid: 1'b1, done: 1'b0,
                                   is_branch: alloc_is_branch, has_dest: alloc_has_dest};
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // The payload is qualified by the valid flags, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            arch_q[tail_q]  <= alloc_dest_arch;
            dpreg_q[tail_q] <= alloc_dest_preg;
            opreg_q[tail_q] <= alloc_old_preg;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(alloc_valid && rob_full))
                else $warning("reorder_buffer: allocation dropped while full");
            assert (!(wb_valid && alloc_fire && wb_tag == tail_q))
                else $error("reorder_buffer: writeback to the tag being allocated");
        end
    end
`endif

`ifdef ROB_COMMIT_STATS_EN
    rob_commit_stats u_stats (
        .clk              (clk),
        .reset            (reset),
        .commit_i         (commit_fire),
        .branch_i         (ent_q[head_q].is_branch),
        .full_i           (rob_full),
        .commits_o        (stat_commits),
        .branch_commits_o (stat_branch_commits),
        .full_cycles_o    (stat_full_cycles)
    );
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (depth 8 by default).
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 3
`endif

module tb_reorder_buffer;
    localparam int TW    = `ROB_SIZE_WIDTH;
    localparam int DEPTH = 1 << TW;

    logic          clk = 1'b0;
    logic          reset;
    logic          alloc_valid, alloc_is_branch, alloc_has_dest;
    logic [4:0]    alloc_dest_arch;
    logic [5:0]    alloc_dest_preg, alloc_old_preg;
    logic [TW-1:0] alloc_tag;
    logic          rob_full, rob_empty;
    logic          wb_valid;
    logic [TW-1:0] wb_tag;
    logic          commit_valid, commited_branch_op, commit_has_dest;
    logic [TW-1:0] commited_branch_tag;
    logic [4:0]    commit_dest_arch;
    logic [5:0]    commit_dest_preg, commit_old_preg;
`ifdef ROB_COMMIT_STATS_EN
    logic [31:0]   stat_commits, stat_branch_commits, stat_full_cycles;
`endif

    always #5 clk = ~clk;

    reorder_buffer #(.PREG_WIDTH(6), .AREG_WIDTH(5)) dut (
        .clk                 (clk),
        .reset               (reset),
        .alloc_valid         (alloc_valid),
        .alloc_is_branch     (alloc_is_branch),
        .alloc_has_dest      (alloc_has_dest),
        .alloc_dest_arch     (alloc_dest_arch),
        .alloc_dest_preg     (alloc_dest_preg),
        .alloc_old_preg      (alloc_old_preg),
        .alloc_tag           (alloc_tag),
        .rob_full            (rob_full),
        .rob_empty           (rob_empty),
        .wb_valid            (wb_valid),
        .wb_tag              (wb_tag),
        .commit_valid        (commit_valid),
        .commited_branch_op  (commited_branch_op),
        .commited_branch_tag (commited_branch_tag),
        .commit_has_dest     (commit_has_dest),
        .commit_dest_arch    (commit_dest_arch),
        .commit_dest_preg    (commit_dest_preg),
        .commit_old_preg     (commit_old_preg)
`ifdef ROB_COMMIT_STATS_EN
        ,
        .stat_commits        (stat_commits),
        .stat_branch_commits (stat_branch_commits),
        .stat_full_cycles    (stat_full_cycles)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid = 0; alloc_is_branch = 0; alloc_has_dest = 0;
        alloc_dest_arch = '0; alloc_dest_preg = '0; alloc_old_preg = '0;
        wb_valid = 0; wb_tag = '0;
    endtask

    task automatic set_alloc(input logic br, input logic hd, input logic [4:0] arch,
                             input logic [5:0] dst, input logic [5:0] old);
        alloc_valid = 1; alloc_is_branch = br; alloc_has_dest = hd;
        alloc_dest_arch = arch; alloc_dest_preg = dst; alloc_old_preg = old;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    logic [5:0] exp_old [0:3*DEPTH-1];
    int         exp_idx;

    initial begin
        do_reset();

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_empty", 32'(rob_empty), 32'd1);
            check("idle_tag", 32'(alloc_tag), 32'd0);
            check("idle_commit", 32'(commit_valid), 32'd0);
        end
        check("idle_full", 32'(rob_full), 32'd0);
        check("idle_oldpreg", 32'(commit_old_preg), 32'd0);

        // Single branch: alloc cycle 1, writeback cycle 3, commit visible cycle 4 only
        set_alloc(1, 0, 5'd0, 6'd0, 6'd0);
        tick();
        idle_inputs();
        check("br_tag_adv", 32'(alloc_tag), 32'd1);
        check("br_not_empty", 32'(rob_empty), 32'd0);
        check("br_c1_commit", 32'(commit_valid), 32'd0);
        tick();
        check("br_c2_commit", 32'(commit_valid), 32'd0);
        wb_valid = 1; wb_tag = '0;
        tick();
        wb_valid = 0;
        check("br_c4_commit", 32'(commit_valid), 32'd1);
        check("br_c4_op", 32'(commited_branch_op), 32'd1);
        check("br_c4_tag", 32'(commited_branch_tag), 32'd0);
        tick();
        check("br_c5_commit", 32'(commit_valid), 32'd0);
        check("br_c5_op", 32'(commited_branch_op), 32'd0);
        check("br_c5_empty", 32'(rob_empty), 32'd1);

        // Out-of-order writeback 2,1,0
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(0, 1, 5'(i + 1), 6'(i + 20), 6'(i + 10));
            tick();
        end
        idle_inputs();
        check("ooo_tag", 32'(alloc_tag), 32'd3);
        check("ooo_gated_dest", 32'(commit_dest_preg), 32'd0);
        wb_valid = 1; wb_tag = 3'd2;
        tick();
        check("ooo_wb2", 32'(commit_valid), 32'd0);
        wb_tag = 3'd1;
        tick();
        check("ooo_wb1", 32'(commit_valid), 32'd0);
        wb_tag = 3'd0;
        tick();
        wb_valid = 0;
        for (int i = 0; i < 3; i++) begin
            check("ooo_cv", 32'(commit_valid), 32'd1);
            check("ooo_ctag", 32'(commited_branch_tag), 32'(i));
            check("ooo_old", 32'(commit_old_preg), 32'(i + 10));
            check("ooo_dst", 32'(commit_dest_preg), 32'(i + 20));
            check("ooo_arch", 32'(commit_dest_arch), 32'(i + 1));
            check("ooo_hd", 32'(commit_has_dest), 32'd1);
            tick();
        end
        check("ooo_done", 32'(commit_valid), 32'd0);
        check("ooo_empty", 32'(rob_empty), 32'd1);

        // Fill to full, then free one slot with alloc_valid held
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_notfull", 32'(rob_full), 32'd0);
            set_alloc(0, 1, 5'(i + 3), 6'(i), 6'(i + 30));
            tick();
        end
        check("fill_full", 32'(rob_full), 32'd1);
        check("fill_tag_wrap", 32'(alloc_tag), 32'd0);
        check("fill_not_empty", 32'(rob_empty), 32'd0);
        set_alloc(0, 1, 5'd31, 6'd63, 6'd63);
        tick();
        check("fill_drop_tag", 32'(alloc_tag), 32'd0);
        check("fill_drop_full", 32'(rob_full), 32'd1);
        wb_valid = 1; wb_tag = '0;
        tick();
        wb_valid = 0;
        check("fill_cv", 32'(commit_valid), 32'd1);
        check("fill_carch", 32'(commit_dest_arch), 32'd3);
        check("fill_still_full", 32'(rob_full), 32'd1);
        tick();
        check("fill_after_commit_full", 32'(rob_full), 32'd0);
        check("fill_after_commit_tag", 32'(alloc_tag), 32'd0);
        check("fill_after_commit_cv", 32'(commit_valid), 32'd0);
        tick();
        idle_inputs();
        check("fill_accept_tag", 32'(alloc_tag), 32'd1);
        check("fill_accept_full", 32'(rob_full), 32'd1);

        // Wrap-around: 3*DEPTH instructions, writeback two cycles after allocation
        do_reset();
        exp_idx = 0;
        for (int t = 0; t < 3 * DEPTH + 4; t++) begin
            idle_inputs();
            if (t < 3 * DEPTH) begin
                exp_old[t] = 6'((t * 5 + 3) & 63);
                set_alloc(((t % 3) == 0), 1, 5'(t & 31), 6'(t & 63), exp_old[t]);
            end
            if (t >= 2 && t - 2 < 3 * DEPTH) begin
                wb_valid = 1;
                wb_tag = TW'(t - 2);
            end
            tick();
            if (t < 3 * DEPTH) check("wrap_tag", 32'(alloc_tag), 32'((t + 1) % DEPTH));
            check("wrap_cv", 32'(commit_valid), 32'((t >= 2 && t < 3 * DEPTH + 2) ? 1 : 0));
            if (commit_valid && exp_idx < 3 * DEPTH) begin
                check("wrap_ctag", 32'(commited_branch_tag), 32'(exp_idx % DEPTH));
                check("wrap_old", 32'(commit_old_preg), 32'(exp_old[exp_idx]));
                check("wrap_br", 32'(commited_branch_op), 32'(((exp_idx % 3) == 0) ? 1 : 0));
                exp_idx++;
            end
        end
        check("wrap_count", 32'(exp_idx), 32'(3 * DEPTH));
        check("wrap_empty", 32'(rob_empty), 32'd1);

        // Reset with 5 entries pending
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_alloc(0, 1, 5'(i), 6'(i), 6'(i));
            tick();
        end
        idle_inputs();
        check("rst5_tag_before", 32'(alloc_tag), 32'd5);
        reset = 0;
        wb_valid = 1; wb_tag = '0;
        tick();
        reset = 1;
        wb_valid = 0;
        check("rst5_empty", 32'(rob_empty), 32'd1);
        check("rst5_tag", 32'(alloc_tag), 32'd0);
        check("rst5_full", 32'(rob_full), 32'd0);
        for (int i = 0; i < 5; i++) begin
            wb_valid = 1; wb_tag = TW'(i);
            tick();
            check("rst5_nocommit", 32'(commit_valid), 32'd0);
            check("rst5_still_empty", 32'(rob_empty), 32'd1);
        end
        idle_inputs();
        tick();
        check("rst5_final", 32'(commit_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
